// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the iterative CORDIC rotation engine.
package cordic_pkg;
    localparam int DATA_W = 32;
    localparam int Z_W    = 33;
    localparam int ADDR_W = 5;

    // CORDIC gain compensation 0.607253 in Q2.30, preloaded into x
    localparam logic signed [DATA_W-1:0] K_INIT = 32'sh26DD3B6A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; direction chosen from the sign of the residual angle.
module cordic_stage
    import cordic_pkg::*;
(
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [DATA_W-1:0] i_y,
    input  logic signed [Z_W-1:0]    i_z,
    input  logic        [ADDR_W-1:0] i_idx,
    input  logic        [DATA_W-1:0] i_atan,
    output logic signed [DATA_W-1:0] o_x,
    output logic signed [DATA_W-1:0] o_y,
    output logic signed [Z_W-1:0]    o_z
);
    logic signed [DATA_W-1:0] w_x_sh;
    logic signed [DATA_W-1:0] w_y_sh;
    logic signed [Z_W-1:0]    w_atan;
    logic                     w_neg;

    assign w_x_sh = i_x >>> i_idx;
    assign w_y_sh = i_y >>> i_idx;
    assign w_atan = $signed({1'b0, i_atan});
    assign w_neg  = i_z[Z_W-1];

    // d = -1 when the residual angle is negative, otherwise +1
    assign o_x = w_neg ? (i_x + w_y_sh) : (i_x - w_y_sh);
    assign o_y = w_neg ? (i_y - w_x_sh) : (i_y + w_x_sh);
    assign o_z = w_neg ? (i_z + w_atan) : (i_z - w_atan);
endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: cos(theta), one micro-rotation per clock, atan words from an external ROM.
// Define CORDIC_SIN_OUT_EN to add the o_sin_out port and its output register.
//
// state   | meaning
// IDLE    | waiting for i_start, theta captured on the accepting edge
// RUN     | one micro-rotation per cycle, o_rom_addr = iteration index
// DONE    | results registered, o_done pulses, back to IDLE
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic        [DATA_W-1:0] i_theta,
    output logic                     o_busy,
    output logic                     o_done,
    output logic signed [DATA_W-1:0] o_cos_out,
    output logic        [ADDR_W-1:0] o_rom_addr,
    input  logic        [DATA_W-1:0] i_rom_data
`ifdef CORDIC_SIN_OUT_EN
    ,
    output logic signed [DATA_W-1:0] o_sin_out
`endif
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ITERATIONS - 1);

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_x;
    logic signed [DATA_W-1:0] r_y;
    logic signed [Z_W-1:0]    r_z;
    logic        [ADDR_W-1:0] r_idx;
    logic                     r_busy;
    logic                     r_done;
    logic signed [DATA_W-1:0] r_cos;
`ifdef CORDIC_SIN_OUT_EN
    logic signed [DATA_W-1:0] r_sin;
`endif

    logic signed [DATA_W-1:0] w_x_nxt;
    logic signed [DATA_W-1:0] w_y_nxt;
    logic signed [Z_W-1:0]    w_z_nxt;

    cordic_stage u_stage (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_idx  (r_idx),
        .i_atan (i_rom_data),
        .o_x    (w_x_nxt),
        .o_y    (w_y_nxt),
        .o_z    (w_z_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cos   <= '0;
`ifdef CORDIC_SIN_OUT_EN
            r_sin   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= i_start;
                    if (i_start) begin
                        r_x     <= K_INIT;
                        r_y     <= '0;
                        r_z     <= {i_theta[DATA_W-1], i_theta};
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_busy <= 1'b1;
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_idx  <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // busy stays high through the done cycle; cleared by IDLE next edge
                    r_busy  <= 1'b1;
                    r_done  <= 1'b1;
                    r_cos   <= r_x;
`ifdef CORDIC_SIN_OUT_EN
                    r_sin   <= r_y;
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_cos_out  = r_cos;
    assign o_rom_addr = (r_state == ST_RUN) ? r_idx : '0;
`ifdef CORDIC_SIN_OUT_EN
    assign o_sin_out  = r_sin;
`endif
endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter: directed angles, expected cos/sin queued at acceptance.
module tb_cordic_iter;
    localparam int  LAT = 17;
    localparam longint TOL = 65536;

    typedef struct {
        longint cos_e;
        longint sin_e;
        int     acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] theta;
    logic        busy;
    logic        done;
    logic [31:0] cos_out;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
`ifdef CORDIC_SIN_OUT_EN
    logic [31:0] sin_out;
`endif

    logic [31:0] rom_tbl [0:31];
    exp_t        sb [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = rom_tbl[rom_addr];

    cordic_iter #(.ITERATIONS(16)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_theta    (theta),
        .o_busy     (busy),
        .o_done     (done),
        .o_cos_out  (cos_out),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data)
`ifdef CORDIC_SIN_OUT_EN
        ,
        .o_sin_out  (sin_out)
`endif
    );

    function automatic longint q30(real r);
        return longint'($rtoi(r * 1073741824.0));
    endfunction

    task automatic chk_eq(string nm, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_near(string nm, longint act, longint exp);
        longint diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        n_checks++;
        if (diff > TOL) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, TOL);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk_eq("done_latency", cyc, e.acc + LAT);
                chk_eq("busy_in_done", longint'(busy), 1);
                chk_near("cos_out", longint'($signed(cos_out)), e.cos_e);
`ifdef CORDIC_SIN_OUT_EN
                chk_near("sin_out", longint'($signed(sin_out)), e.sin_e);
`endif
            end
        end
    end

    task automatic issue(input logic [31:0] th, input real c, input real s);
        exp_t e;
        start = 1'b1;
        theta = th;
        e.cos_e = q30(c);
        e.sin_e = q30(s);
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        theta = 32'h5A5A5A5A;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int dn;
        longint held;
        for (int k = 0; k < 32; k++) begin
            rom_tbl[k] = 32'($rtoi($atan(2.0 ** (-k)) * 2147483648.0 + 0.5));
        end
        reset = 1'b1;
        start = 1'b1;
        theta = 32'h40000000;
        repeat (3) @(negedge clk);
        chk_eq("reset_busy", longint'(busy), 0);
        chk_eq("reset_done", longint'(done), 0);
        chk_eq("reset_cos", longint'(cos_out), 0);
        chk_eq("reset_rom_addr", longint'(rom_addr), 0);
`ifdef CORDIC_SIN_OUT_EN
        chk_eq("reset_sin", longint'(sin_out), 0);
`endif
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // theta = 0
        issue(32'h00000000, 1.0, 0.0);
        chk_eq("busy_after_accept", longint'(busy), 1);
        wait_idle(40);
        @(negedge clk);
        chk_eq("busy_after_done", longint'(busy), 0);
        held = longint'($signed(cos_out));
        repeat (3) @(negedge clk);
        chk_eq("cos_hold", longint'($signed(cos_out)), held);

        // theta = 0.5 with a stray start during RUN
        dn = n_done;
        issue(32'h40000000, 0.8775825619, 0.4794255386);
        repeat (4) @(negedge clk);
        start = 1'b1;
        theta = 32'h00000000;
        @(negedge clk);
        start = 1'b0;
        wait_idle(40);
        repeat (5) @(negedge clk);
        chk_eq("single_done_pulse", longint'(n_done - dn), 1);

        // theta = -1.0, check ROM address walk
        issue(32'h80000000, 0.5403023059, -0.8414709848);
        for (int k = 0; k < 16; k++) begin
            chk_eq($sformatf("rom_addr_%0d", k), longint'(rom_addr), longint'(k));
            @(negedge clk);
        end
        chk_eq("rom_addr_done", longint'(rom_addr), 0);
        wait_idle(10);
        @(negedge clk);

        // reset at RUN iteration 7
        dn = n_done;
        issue(32'h40000000, 0.8775825619, 0.4794255386);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        chk_eq("abort_busy", longint'(busy), 0);
        chk_eq("abort_cos", longint'(cos_out), 0);
        chk_eq("abort_done", longint'(done), 0);
        chk_eq("abort_rom_addr", longint'(rom_addr), 0);
        repeat (20) @(negedge clk);
        chk_eq("abort_no_done", longint'(n_done - dn), 0);
        issue(32'h20000000, 0.9689124217, 0.2474039593);
        wait_idle(40);
        @(negedge clk);

        // start held high for three back-to-back runs
        begin
            logic [31:0] th [3];
            real         cr [3];
            real         sr [3];
            exp_t        e;
            th[0] = 32'h00000000; cr[0] = 1.0;          sr[0] = 0.0;
            th[1] = 32'h20000000; cr[1] = 0.9689124217; sr[1] = 0.2474039593;
            th[2] = 32'hC0000000; cr[2] = 0.8775825619; sr[2] = -0.4794255386;
            start = 1'b1;
            for (int j = 0; j < 3; j++) begin
                theta   = th[j];
                e.cos_e = q30(cr[j]);
                e.sin_e = q30(sr[j]);
                e.acc   = cyc + 1;
                sb.push_back(e);
                @(negedge clk);
                theta = 32'h7FFFFFFF;
                if (j == 2) start = 1'b0;
                else repeat (17) @(negedge clk);
            end
        end
        wait_idle(40);
        repeat (3) @(negedge clk);
        chk_eq("scoreboard_empty", longint'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
